// File: rtl/dram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_pkg
// Description : Shared types and constants for the DRAM responder: FSM state
//               encoding, default processor read latency and latency-counter
//               width.
// Revision    : 1.0  initial release
// ============================================================================
package dram_pkg;

    // Responder FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        RD_WAIT = 3'd2,
        HOST    = 3'd3,
        DONE    = 3'd4
    } state_t;

    // Default processor read latency in cycles (legal range 1..15).
    localparam int DEFAULT_READ_LAT = 2;

    // Width of the read-latency down-counter; holds READ_LAT-1 up to 14.
    localparam int CNT_W = 4;

endpackage : dram_pkg
`default_nettype wire

// File: rtl/dram_array.sv
`default_nettype none
// ============================================================================
// Module      : dram_array
// Description : Single-port word array with synchronous write and a
//               registered synchronous read (read-before-write on a
//               same-address write edge). Contents are never reset.
// Ports       : clk   - clock, rising edge
//               we    - write enable
//               addr  - word address
//               wdata - write data
//               rdata - registered read data of addr sampled at the last edge
// Revision    : 1.0  initial release
// ============================================================================
module dram_array #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule : dram_array
`default_nettype wire

// File: rtl/dram_responder.sv
`default_nettype none
// ============================================================================
// Module      : dram_responder
// Description : Data-memory responder for the processor DRAM port plus a host
//               load/dump port. Processor reads return after READ_LAT cycles,
//               writes and host accesses take a fixed single cycle. Every
//               access ends with a one-cycle DONE guard state so a request
//               level still high during its completion pulse is not served
//               twice.
// Ports       : Clk, Rst_n            - clock / async active-low reset
//               memREAD, memWRITE     - processor request levels
//               DRAM_addr, DRAM_dataOut - processor address / write data
//               DRAM_dataIn, memDONE  - processor read data / done pulse
//               busy, proto_err       - not-idle flag / sticky R+W error
//               host_req, host_wr, host_addr, host_wdata - host request
//               host_rdata, host_ack  - host read data / ack pulse
// Revision    : 1.0  initial release
// ============================================================================
module dram_responder
    import dram_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int READ_LAT   = DEFAULT_READ_LAT
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  memREAD,
    input  logic                  memWRITE,
    input  logic [ADDR_WIDTH-1:0] DRAM_addr,
    input  logic [WIDTH-1:0]      DRAM_dataOut,
    output logic [WIDTH-1:0]      DRAM_dataIn,
    output logic                  memDONE,
    output logic                  busy,
    output logic                  proto_err,
    input  logic                  host_req,
    input  logic                  host_wr,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [WIDTH-1:0]      host_wdata,
    output logic [WIDTH-1:0]      host_rdata,
    output logic                  host_ack
);

    // Counter preload: the edge that leaves IDLE is latency cycle 0, so the
    // data edge comes READ_LAT-1 decrements later.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      wdata_q;
    logic                  host_wr_q;
    logic [CNT_W-1:0]      cnt;

    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_addr;
    logic [WIDTH-1:0]      arr_rdata;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next state and array port steering
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        arr_we    = 1'b0;
        arr_addr  = addr_q;

        case (state)
            IDLE: begin
                // The array is addressed straight from the winning request
                // while idle, so its registered read already holds the word
                // one edge after the sampling edge. This is what lets a
                // READ_LAT of 1 and a 1-cycle host read work.
                if (host_req) begin
                    arr_addr  = host_addr;
                    state_nxt = HOST;
                end else if (memWRITE) begin
                    arr_addr  = DRAM_addr;
                    state_nxt = WR;
                end else if (memREAD) begin
                    arr_addr  = DRAM_addr;
                    state_nxt = RD_WAIT;
                end else begin
                    arr_addr  = DRAM_addr;
                end
            end
            WR: begin
                arr_we    = 1'b1;
                state_nxt = DONE;
            end
            RD_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            HOST: begin
                arr_we    = host_wr_q;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // ------------------------------------------------------------------
    // Request latches, latency counter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            host_wr_q   <= 1'b0;
            cnt         <= '0;
            DRAM_dataIn <= '0;
            host_rdata  <= '0;
            memDONE     <= 1'b0;
            host_ack    <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            memDONE  <= 1'b0;
            host_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (host_req) begin
                        addr_q    <= host_addr;
                        wdata_q   <= host_wdata;
                        host_wr_q <= host_wr;
                    end else if (memWRITE) begin
                        addr_q  <= DRAM_addr;
                        wdata_q <= DRAM_dataOut;
                        if (memREAD) begin
                            proto_err <= 1'b1;
                        end
                    end else if (memREAD) begin
                        addr_q <= DRAM_addr;
                        cnt    <= CNT_INIT;
                    end
                end
                WR: begin
                    memDONE <= 1'b1;
                end
                RD_WAIT: begin
                    if (cnt == '0) begin
                        DRAM_dataIn <= arr_rdata;
                        memDONE     <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOST: begin
                    host_ack <= 1'b1;
                    if (!host_wr_q) begin
                        host_rdata <= arr_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Working data array
    // ------------------------------------------------------------------
    dram_array #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (Clk),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

endmodule : dram_responder
`default_nettype wire

// File: tb/tb_dram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_responder
// Description : Directed self-checking bench for dram_responder. One main
//               instance (READ_LAT=2) plus READ_LAT=1 and READ_LAT=15
//               instances for the latency sweep; the sweep instances share
//               the write and host stimulus but have their own read requests.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dram_responder;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       memREAD = 1'b0;
    logic       memWRITE = 1'b0;
    logic [7:0] DRAM_addr = '0;
    logic [7:0] DRAM_dataOut = '0;
    logic [7:0] DRAM_dataIn;
    logic       memDONE;
    logic       busy;
    logic       proto_err;
    logic       host_req = 1'b0;
    logic       host_wr = 1'b0;
    logic [7:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic [7:0] host_rdata;
    logic       host_ack;

    logic       rd_l1 = 1'b0;
    logic       rd_l15 = 1'b0;
    logic [7:0] dout_l1, dout_l15, hrd_l1, hrd_l15;
    logic       done_l1, done_l15, busy_l1, busy_l15;
    logic       perr_l1, perr_l15, hack_l1, hack_l15;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    dram_responder #(.WIDTH(8), .ADDR_WIDTH(8), .READ_LAT(2)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .memREAD(memREAD), .memWRITE(memWRITE),
        .DRAM_addr(DRAM_addr), .DRAM_dataOut(DRAM_dataOut),
        .DRAM_dataIn(DRAM_dataIn), .memDONE(memDONE), .busy(busy),
        .proto_err(proto_err), .host_req(host_req), .host_wr(host_wr),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack)
    );

    dram_responder #(.WIDTH(8), .ADDR_WIDTH(8), .READ_LAT(1)) u_lat1 (
        .Clk(Clk), .Rst_n(Rst_n), .memREAD(rd_l1), .memWRITE(memWRITE),
        .DRAM_addr(DRAM_addr), .DRAM_dataOut(DRAM_dataOut),
        .DRAM_dataIn(dout_l1), .memDONE(done_l1), .busy(busy_l1),
        .proto_err(perr_l1), .host_req(host_req), .host_wr(host_wr),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(hrd_l1), .host_ack(hack_l1)
    );

    dram_responder #(.WIDTH(8), .ADDR_WIDTH(8), .READ_LAT(15)) u_lat15 (
        .Clk(Clk), .Rst_n(Rst_n), .memREAD(rd_l15), .memWRITE(memWRITE),
        .DRAM_addr(DRAM_addr), .DRAM_dataOut(DRAM_dataOut),
        .DRAM_dataIn(dout_l15), .memDONE(done_l15), .busy(busy_l15),
        .proto_err(perr_l15), .host_req(host_req), .host_wr(host_wr),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(hrd_l15), .host_ack(hack_l15)
    );

    // ------------------------------------------------------------------
    // Transaction drivers. Requests are raised 1 ns after a rising edge and
    // outputs are observed on falling edges. cyc counts falling edges from
    // the request: the sampling edge falls between edge 1 and edge 2, so a
    // 1-cycle access completes at cyc 3 and a read of latency L at L+2.
    // -1 means the completion never came within the bound.
    // ------------------------------------------------------------------
    task automatic do_proc_write(input logic [7:0] a, input logic [7:0] d,
                                 input logic with_read, output int cyc,
                                 output logic pulse_after);
        @(posedge Clk); #1;
        DRAM_addr    = a;
        DRAM_dataOut = d;
        memWRITE     = 1'b1;
        memREAD      = with_read;
        cyc          = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk);
            if (memDONE) begin
                cyc = i;
                break;
            end
        end
        memWRITE = 1'b0;
        memREAD  = 1'b0;
        @(negedge Clk);
        pulse_after = memDONE;
    endtask

    task automatic do_proc_read(input logic [7:0] a, output int cyc,
                                output logic [7:0] data,
                                output logic pulse_after, output logic busy_ok);
        @(posedge Clk); #1;
        DRAM_addr = a;
        memREAD   = 1'b1;
        cyc       = -1;
        data      = 'x;
        busy_ok   = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk);
            if (i >= 2 && !busy) busy_ok = 1'b0;
            if (memDONE) begin
                cyc  = i;
                data = DRAM_dataIn;
                break;
            end
        end
        memREAD = 1'b0;
        @(negedge Clk);
        pulse_after = memDONE;
    endtask

    task automatic do_host(input logic wr, input logic [7:0] a,
                           input logic [7:0] d, output int cyc,
                           output logic [7:0] rd, output logic pulse_after);
        @(posedge Clk); #1;
        host_wr    = wr;
        host_addr  = a;
        host_wdata = d;
        host_req   = 1'b1;
        cyc        = -1;
        rd         = 'x;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk);
            if (host_ack) begin
                cyc = i;
                rd  = host_rdata;
                break;
            end
        end
        host_req = 1'b0;
        @(negedge Clk);
        pulse_after = host_ack;
    endtask

    // sel = 0 drives the READ_LAT=1 instance, sel = 1 the READ_LAT=15 one.
    task automatic do_sweep_read(input logic sel, input logic [7:0] a,
                                 output int cyc, output logic [7:0] data,
                                 output logic busy_ok);
        @(posedge Clk); #1;
        DRAM_addr = a;
        if (sel) rd_l15 = 1'b1; else rd_l1 = 1'b1;
        cyc     = -1;
        data    = 'x;
        busy_ok = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge Clk);
            if (i >= 2 && !(sel ? busy_l15 : busy_l1)) busy_ok = 1'b0;
            if (sel ? done_l15 : done_l1) begin
                cyc  = i;
                data = sel ? dout_l15 : dout_l1;
                break;
            end
        end
        rd_l1  = 1'b0;
        rd_l15 = 1'b0;
        @(negedge Clk);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset;
        Rst_n = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n_checks++;
        if ({DRAM_dataIn, host_rdata} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h expected 00/00", DRAM_dataIn, host_rdata);
        end
        n_checks++;
        if ({memDONE, host_ack, busy, proto_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {memDONE, host_ack, busy, proto_err});
        end
        Rst_n = 1'b1;
        @(negedge Clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_write_read;
        int cyc; logic pa, bok; logic [7:0] d;
        do_proc_write(8'h10, 8'hA5, 1'b0, cyc, pa);
        n_checks++;
        if (cyc !== 3) begin
            n_fail++;
            $display("FAIL wr_latency: got %0d expected 3", cyc);
        end
        n_checks++;
        if (pa !== 1'b0 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_pulse: done_after=%b proto_err=%b expected 0/0", pa, proto_err);
        end
        do_proc_read(8'h10, cyc, d, pa, bok);
        n_checks++;
        if (cyc !== 4) begin
            n_fail++;
            $display("FAIL rd_latency: got %0d expected 4", cyc);
        end
        n_checks++;
        if (d !== 8'hA5) begin
            n_fail++;
            $display("FAIL rd_data: got %h expected a5", d);
        end
        n_checks++;
        if (pa !== 1'b0 || bok !== 1'b1) begin
            n_fail++;
            $display("FAIL rd_pulse_busy: done_after=%b busy_ok=%b expected 0/1", pa, bok);
        end
    endtask

    task automatic test_proto_err;
        int cyc; logic pa, bok; logic [7:0] d;
        do_proc_write(8'h20, 8'h5A, 1'b1, cyc, pa);
        n_checks++;
        if (cyc !== 3 || proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL proto_write: cyc=%0d proto_err=%b expected 3/1", cyc, proto_err);
        end
        n_checks++;
        if (DRAM_dataIn !== 8'hA5) begin
            n_fail++;
            $display("FAIL dataIn_hold: got %h expected a5", DRAM_dataIn);
        end
        do_proc_read(8'h20, cyc, d, pa, bok);
        n_checks++;
        if (d !== 8'h5A || cyc !== 4) begin
            n_fail++;
            $display("FAIL proto_readback: got %h at %0d expected 5a at 4", d, cyc);
        end
        do_proc_write(8'h21, 8'h77, 1'b0, cyc, pa);
        n_checks++;
        if (proto_err !== 1'b1) begin
            n_fail++;
            $display("FAIL proto_sticky: got %b expected 1", proto_err);
        end
    endtask

    task automatic test_reset_mid_read;
        int cyc; int bad; logic pa, bok; logic [7:0] d;
        @(posedge Clk); #1;
        DRAM_addr = 8'h10;
        memREAD   = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_read_busy: got %b expected 1", busy);
        end
        Rst_n   = 1'b0;
        memREAD = 1'b0;
        #1;
        n_checks++;
        if ({DRAM_dataIn, host_rdata, memDONE, host_ack, busy, proto_err} !== 20'h0) begin
            n_fail++;
            $display("FAIL async_reset: got dataIn=%h hrd=%h flags=%b expected all 0",
                     DRAM_dataIn, host_rdata, {memDONE, host_ack, busy, proto_err});
        end
        @(negedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (memDONE || busy) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL dropped_read: %0d active cycles after release expected 0", bad);
        end
        do_proc_read(8'h10, cyc, d, pa, bok);
        n_checks++;
        if (d !== 8'hA5) begin
            n_fail++;
            $display("FAIL retained_10: got %h expected a5", d);
        end
        do_proc_read(8'h20, cyc, d, pa, bok);
        n_checks++;
        if (d !== 8'h5A) begin
            n_fail++;
            $display("FAIL retained_20: got %h expected 5a", d);
        end
    endtask

    task automatic test_host_preload;
        int cyc; int bad; logic pa, bok; logic [7:0] d;
        logic [7:0] av;
        bad = 0;
        for (int a = 0; a < 256; a++) begin
            av = a[7:0];
            do_host(1'b1, av, ~av, cyc, d, pa);
            if (cyc != 3 || pa) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL preload_acks: %0d bad acks expected 0", bad);
        end
        do_proc_read(8'h3C, cyc, d, pa, bok);
        n_checks++;
        if (d !== 8'hC3) begin
            n_fail++;
            $display("FAIL preload_proc_read: got %h expected c3", d);
        end
        do_host(1'b0, 8'hFF, 8'h00, cyc, d, pa);
        n_checks++;
        if (d !== 8'h00 || cyc !== 3) begin
            n_fail++;
            $display("FAIL host_read_ff: got %h at %0d expected 00 at 3", d, cyc);
        end
        n_checks++;
        if (pa !== 1'b0) begin
            n_fail++;
            $display("FAIL host_ack_width: after=%b expected 0", pa);
        end
    endtask

    task automatic test_arbitration;
        int t_ack, t_done, n_ack, n_done, bad_sync;
        logic [7:0] hr, pr;
        @(posedge Clk); #1;
        host_wr   = 1'b0;
        host_addr = 8'h3C;
        DRAM_addr = 8'hFF;
        host_req  = 1'b1;
        memREAD   = 1'b1;
        t_ack = 0; t_done = 0; n_ack = 0; n_done = 0; bad_sync = 0;
        hr = 'x; pr = 'x;
        for (int i = 1; i <= 16; i++) begin
            @(negedge Clk);
            if (hack_l1 !== host_ack || hack_l15 !== host_ack) bad_sync++;
            if (host_ack) begin
                n_ack++;
                if (t_ack == 0) begin t_ack = i; hr = host_rdata; end
                host_req = 1'b0;
            end
            if (memDONE) begin
                n_done++;
                if (t_done == 0) begin t_done = i; pr = DRAM_dataIn; end
                memREAD = 1'b0;
            end
        end
        host_req = 1'b0;
        memREAD  = 1'b0;
        n_checks++;
        if (t_ack !== 3 || hr !== 8'hC3) begin
            n_fail++;
            $display("FAIL arb_host_first: ack at %0d data %h expected 3 c3", t_ack, hr);
        end
        n_checks++;
        if (t_done !== 7 || pr !== 8'h00) begin
            n_fail++;
            $display("FAIL arb_proc_second: done at %0d data %h expected 7 00", t_done, pr);
        end
        n_checks++;
        if (n_ack !== 1 || n_done !== 1) begin
            n_fail++;
            $display("FAIL arb_single_service: acks=%0d dones=%0d expected 1/1", n_ack, n_done);
        end
        n_checks++;
        if (bad_sync !== 0 || hrd_l1 !== 8'hC3 || hrd_l15 !== 8'hC3) begin
            n_fail++;
            $display("FAIL arb_sweep_host: sync_bad=%0d hrd=%h/%h expected 0 c3/c3",
                     bad_sync, hrd_l1, hrd_l15);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL arb_idle_after: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_latency_sweep;
        int cyc; logic bok; logic [7:0] d;
        do_sweep_read(1'b0, 8'h3C, cyc, d, bok);
        n_checks++;
        if (cyc !== 3 || d !== 8'hC3) begin
            n_fail++;
            $display("FAIL lat1_read: at %0d data %h expected 3 c3", cyc, d);
        end
        n_checks++;
        if (bok !== 1'b1) begin
            n_fail++;
            $display("FAIL lat1_busy: got %b expected 1", bok);
        end
        do_sweep_read(1'b1, 8'h3C, cyc, d, bok);
        n_checks++;
        if (cyc !== 17 || d !== 8'hC3) begin
            n_fail++;
            $display("FAIL lat15_read: at %0d data %h expected 17 c3", cyc, d);
        end
        n_checks++;
        if (bok !== 1'b1) begin
            n_fail++;
            $display("FAIL lat15_busy: got %b expected 1", bok);
        end
        n_checks++;
        if ({perr_l1, perr_l15, done_l1, done_l15} !== 4'b0000) begin
            n_fail++;
            $display("FAIL sweep_quiet: got %b expected 0000",
                     {perr_l1, perr_l15, done_l1, done_l15});
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_proto_err();
        test_reset_mid_read();
        test_host_preload();
        test_arbitration();
        test_latency_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dram_responder
`default_nettype wire
